// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 detector and its hit logger: default widths,
// the timestamp word type and the detector state encoding.
package seq_pkg;

    localparam int TS_WIDTH_DEF  = 16;
    localparam int CNT_WIDTH_DEF = 8;
    localparam int DEPTH_DEF     = 4;

    typedef logic [TS_WIDTH_DEF-1:0] ts_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEQ_1    = 3'd1,
        SEQ_10   = 3'd2,
        SEQ_101  = 3'd3,
        SEQ_1011 = 3'd4
    } det_state_e;

    // Pointer width with one extra wrap bit above the index.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/seq_ts_fifo.sv
// Synchronous FIFO for timestamps. Pointers carry a wrap bit so full and empty
// are distinguished without a separate count register.
module seq_ts_fifo
    import seq_pkg::*;
#(
    parameter int WIDTH = TS_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_en_s;
    logic             rd_en_s;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    // A pop frees the slot in the same edge, so a full FIFO still accepts a push.
    assign rd_en_s = pop && !empty;
    assign wr_en_s = push && (!full || rd_en_s);

    // Next-state for pointers and storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are meaningless while empty so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/seq_hit_logger.sv
// Timestamps detector hits against a free-running counter, queues them for a
// valid/ready consumer and keeps hit count, sticky overflow and threshold irq.
module seq_hit_logger
    import seq_pkg::*;
#(
    parameter int TS_WIDTH  = TS_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   seq_seen,
    input  logic                   clear,
    input  logic [CNT_WIDTH-1:0]   thresh,
    output logic [CNT_WIDTH-1:0]   hit_count,
    output logic                   irq,
    output logic                   overflow,
    output logic                   ts_valid,
    output logic [TS_WIDTH-1:0]    ts_data,
    input  logic                   ts_ready,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam logic [TS_WIDTH-1:0]  TS_ONE  = {{(TS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] HIT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] HIT_MAX = {CNT_WIDTH{1'b1}};

    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [CNT_WIDTH-1:0] hit_q, hit_d;
    logic                 overflow_q, overflow_d;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 pop_s;
    logic                 drop_s;

    assign pop_s  = !fifo_empty_s && ts_ready;
    assign drop_s = seq_seen && fifo_full_s && !pop_s;

    seq_ts_fifo #(
        .WIDTH (TS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (seq_seen),
        .pop   (pop_s),
        .wdata (ts_q),
        .rdata (ts_data),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    // Next-state for timestamp, saturating hit count and sticky overflow.
    always_comb begin
        ts_d       = ts_q + TS_ONE;
        hit_d      = hit_q;
        overflow_d = overflow_q;
        if (clear) begin
            // An event coinciding with clear is the first event of the new epoch.
            hit_d      = seq_seen ? HIT_ONE : {CNT_WIDTH{1'b0}};
            overflow_d = drop_s;
        end else begin
            if (seq_seen && (hit_q != HIT_MAX)) begin
                hit_d = hit_q + HIT_ONE;
            end else begin
                hit_d = hit_q;
            end
            overflow_d = overflow_q | drop_s;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q       <= {TS_WIDTH{1'b0}};
            hit_q      <= {CNT_WIDTH{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            hit_q      <= hit_d;
            overflow_q <= overflow_d;
        end
    end

    assign hit_count = hit_q;
    assign overflow  = overflow_q;
    assign ts_valid  = !fifo_empty_s;
    assign irq       = (thresh != {CNT_WIDTH{1'b0}}) && (hit_q >= thresh);

endmodule

// File: tb/tb_seq_hit_logger.sv
// Self-checking bench for seq_hit_logger: a fixed vector table, directed corner
// sequences and a randomized run, all against a queue-based reference model.
module tb_seq_hit_logger;

    localparam int TSW   = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          seq_seen;
    logic          clear;
    logic [CW-1:0] thresh;
    logic [CW-1:0] hit_count;
    logic          irq;
    logic          overflow;
    logic          ts_valid;
    logic [TSW-1:0] ts_data;
    logic          ts_ready;
    logic [2:0]    fifo_level;

    always #5 clk = ~clk;

    seq_hit_logger #(.TS_WIDTH(TSW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .seq_seen   (seq_seen),
        .clear      (clear),
        .thresh     (thresh),
        .hit_count  (hit_count),
        .irq        (irq),
        .overflow   (overflow),
        .ts_valid   (ts_valid),
        .ts_data    (ts_data),
        .ts_ready   (ts_ready),
        .fifo_level (fifo_level)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_ts  = 0;
    int m_hit = 0;
    bit m_ovf = 1'b0;
    int m_q[$];

    typedef struct {
        logic ss;
        logic rd;
        int   lvl;
        int   hit;
        logic vld;
        int   data;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply the specification's rules for one clock edge to the model.
    task automatic model_edge();
        bit pop;
        bit drop;
        if (reset) begin
            m_ts  = 0;
            m_hit = 0;
            m_ovf = 1'b0;
            m_q.delete();
        end else begin
            pop  = (m_q.size() > 0) && ts_ready;
            drop = seq_seen && (m_q.size() == DEPTH) && !pop;
            if (pop) void'(m_q.pop_front());
            if (seq_seen && !drop) m_q.push_back(m_ts);
            if (clear) begin
                m_hit = seq_seen ? 1 : 0;
                m_ovf = drop;
            end else begin
                if (seq_seen && m_hit < 255) m_hit = m_hit + 1;
                m_ovf = m_ovf | drop;
            end
            m_ts = (m_ts + 1) % 65536;
        end
    endtask

    task automatic compare_model();
        chk("level", fifo_level, m_q.size());
        chk("valid", ts_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("data", ts_data, m_q[0]);
        chk("hit", hit_count, m_hit);
        chk("ovf", overflow, m_ovf);
        chk("irq", irq, (thresh != 0) && (m_hit >= thresh));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    initial begin
        // ts at each edge runs 0..11; events at ts 3, 7, 8, then drain
        vecs[0]  = '{1'b0, 1'b0, 0, 0, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b0, 0, 0, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b0, 0, 0, 1'b0, 0};
        vecs[3]  = '{1'b1, 1'b0, 1, 1, 1'b1, 3};
        vecs[4]  = '{1'b0, 1'b0, 1, 1, 1'b1, 3};
        vecs[5]  = '{1'b0, 1'b0, 1, 1, 1'b1, 3};
        vecs[6]  = '{1'b0, 1'b0, 1, 1, 1'b1, 3};
        vecs[7]  = '{1'b1, 1'b0, 2, 2, 1'b1, 3};
        vecs[8]  = '{1'b1, 1'b0, 3, 3, 1'b1, 3};
        vecs[9]  = '{1'b0, 1'b1, 2, 3, 1'b1, 7};
        vecs[10] = '{1'b0, 1'b1, 1, 3, 1'b1, 8};
        vecs[11] = '{1'b0, 1'b1, 0, 3, 1'b0, 0};

        reset    = 1'b1;
        seq_seen = 1'b0;
        clear    = 1'b0;
        ts_ready = 1'b0;
        thresh   = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_valid", ts_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_hit", hit_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_irq", irq, 0);

        // Test 1: table of vectors
        for (int i = 0; i < 12; i++) begin
            seq_seen = vecs[i].ss;
            ts_ready = vecs[i].rd;
            step();
            chk("t1_level", fifo_level, vecs[i].lvl);
            chk("t1_hit", hit_count, vecs[i].hit);
            chk("t1_valid", ts_valid, vecs[i].vld);
            if (vecs[i].vld) chk("t1_data", ts_data, vecs[i].data);
        end

        // Test 2: overflow with 6 events into 4 slots (clear at ts 12, events at 13..18)
        seq_seen = 1'b0;
        ts_ready = 1'b0;
        clear    = 1'b1;
        step();
        clear    = 1'b0;
        seq_seen = 1'b1;
        repeat (6) step();
        seq_seen = 1'b0;
        chk("t2_level", fifo_level, 4);
        chk("t2_ovf", overflow, 1);
        chk("t2_hit", hit_count, 6);
        ts_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_data", ts_data, 13 + k);
            step();
        end
        chk("t2_empty", ts_valid, 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t2_clr_ovf", overflow, 0);
        chk("t2_clr_hit", hit_count, 0);

        // Test 3: simultaneous push and pop while full
        ts_ready = 1'b0;
        seq_seen = 1'b1;
        repeat (4) step();
        chk("t3_full", fifo_level, 4);
        ts_ready = 1'b1;
        step();
        seq_seen = 1'b0;
        chk("t3_level", fifo_level, 4);
        chk("t3_ovf", overflow, 0);
        repeat (4) step();
        chk("t3_drained", ts_valid, 0);

        // Test 4: threshold interrupt
        clear = 1'b1;
        step();
        clear  = 1'b0;
        thresh = 8'd2;
        seq_seen = 1'b1;
        step();
        seq_seen = 1'b0;
        chk("t4_irq1", irq, 0);
        seq_seen = 1'b1;
        step();
        seq_seen = 1'b0;
        chk("t4_irq2", irq, 1);
        clear    = 1'b1;
        seq_seen = 1'b1;
        step();
        clear    = 1'b0;
        seq_seen = 1'b0;
        chk("t4_clr_hit", hit_count, 1);
        chk("t4_clr_irq", irq, 0);

        // Test 5: saturation, then timestamp wrap
        ts_ready = 1'b1;
        seq_seen = 1'b1;
        repeat (300) step();
        seq_seen = 1'b0;
        chk("t5_sat", hit_count, 255);
        thresh = 8'd0;
        #1;
        chk("t5_irq_off", irq, 0);
        thresh = 8'd255;
        #1;
        chk("t5_irq_max", irq, 1);
        for (int i = 0; i < 70000; i++) begin
            if (m_ts == 65535) break;
            step();
        end
        ts_ready = 1'b0;
        seq_seen = 1'b1;
        step();
        step();
        seq_seen = 1'b0;
        chk("t5_level", fifo_level, 2);
        chk("t5_ffff", ts_data, 16'hFFFF);
        ts_ready = 1'b1;
        step();
        chk("t5_0000", ts_data, 16'h0000);
        step();
        chk("t5_empty", ts_valid, 0);

        // Test 6: reset with entries queued and head stalled
        clear = 1'b1;
        step();
        clear    = 1'b0;
        thresh   = 8'd1;
        ts_ready = 1'b0;
        seq_seen = 1'b1;
        repeat (3) step();
        seq_seen = 1'b0;
        chk("t6_pre_level", fifo_level, 3);
        chk("t6_pre_irq", irq, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_valid", ts_valid, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_hit", hit_count, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_irq", irq, 0);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            seq_seen = 1'($urandom_range(0, 1));
            ts_ready = 1'($urandom_range(0, 1));
            clear    = ($urandom_range(0, 31) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            thresh   = 8'($urandom_range(0, 12));
            step();
        end
        reset    = 1'b0;
        clear    = 1'b0;
        seq_seen = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
